// File: rtl/pe_pkg.sv
// Shared definitions for the PE operand issue / writeback slice.
//   DWIDTH_DEF / AWIDTH_DEF : default operand width and register-file address width
//   ADD_LAT                 : downstream adder latency in cycles
//   PIPE_DEPTH              : in-flight tracking stages (S1 = operands on a/b,
//                             last stage = result on p)
//   op_e                    : add/sub encoding carried on the subtract line
package pe_pkg;
  localparam int unsigned DWIDTH_DEF = 32;
  localparam int unsigned AWIDTH_DEF = 4;
  localparam int unsigned ADD_LAT    = 1;
  localparam int unsigned PIPE_DEPTH = ADD_LAT + 1;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;
endpackage

// File: rtl/pe_regfile.sv
// Local register file for the PE operand issue stage.
//   i_ra_addr/o_ra_data, i_rb_addr/o_rb_data : combinational operand reads
//   i_rd_addr/o_rd_data                      : registered host readout
//   i_wb_*                                   : adder writeback port
//   i_ld_*                                   : host load port
// Writeback and load share one physical write port; the issue stage only
// grants a load when no writeback is pending, so they never collide.
module pe_regfile
  import pe_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] i_ra_addr,
  output logic [DWIDTH-1:0] o_ra_data,
  input  logic [AWIDTH-1:0] i_rb_addr,
  output logic [DWIDTH-1:0] o_rb_data,
  input  logic [AWIDTH-1:0] i_rd_addr,
  output logic [DWIDTH-1:0] o_rd_data,
  input  logic              i_wb_en,
  input  logic [AWIDTH-1:0] i_wb_addr,
  input  logic [DWIDTH-1:0] i_wb_data,
  input  logic              i_ld_en,
  input  logic [AWIDTH-1:0] i_ld_addr,
  input  logic [DWIDTH-1:0] i_ld_data
);
  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic              w_we;
  logic [AWIDTH-1:0] w_waddr;
  logic [DWIDTH-1:0] w_wdata;

  always_comb begin
    w_we      = i_wb_en | i_ld_en;
    w_waddr   = i_wb_en ? i_wb_addr : i_ld_addr;
    w_wdata   = i_wb_en ? i_wb_data : i_ld_data;
    o_ra_data = r_mem[i_ra_addr];
    o_rb_data = r_mem[i_rb_addr];
  end

  // Readout samples the array before this edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem     <= '{default: '0};
      o_rd_data <= '0;
    end else begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(i_wb_en && i_ld_en));
endmodule

// File: rtl/pe_operand_issue.sv
// Operand issue and writeback stage in front of a 1-cycle registered adder.
//   clk, Resetn                     : clock, async active-low reset
//   ins_valid/ins_ready, ins_sub,
//   ins_src_a, ins_src_b, ins_dst   : add/sub instruction handshake
//   ld_valid/ld_ready, ld_addr,
//   ld_data                         : host register load
//   rd_addr, rd_data                : registered host readout (raw array)
//   a, b, subtract                  : registered adder operands
//   p                               : adder result (valid one cycle after a/b)
//   busy                            : any op in S1 or S2
module pe_operand_issue
  import pe_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic              ins_sub,
  input  logic [AWIDTH-1:0] ins_src_a,
  input  logic [AWIDTH-1:0] ins_src_b,
  input  logic [AWIDTH-1:0] ins_dst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [DWIDTH-1:0] ld_data,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic [DWIDTH-1:0] a,
  output logic [DWIDTH-1:0] b,
  output logic              subtract,
  input  logic [DWIDTH-1:0] p,
  output logic              busy
);
  localparam int unsigned S2 = PIPE_DEPTH - 1;

  // Stage 0 is S1 (operands on a/b), stage S2 is the op whose result is on p.
  logic [PIPE_DEPTH-1:0]             r_pipe_valid;
  logic [PIPE_DEPTH-1:0][AWIDTH-1:0] r_pipe_dst;
  logic [DWIDTH-1:0]                 r_a;
  logic [DWIDTH-1:0]                 r_b;
  logic                              r_subtract;

  logic              w_s1_valid;
  logic [AWIDTH-1:0] w_s1_dst;
  logic              w_s2_valid;
  logic [AWIDTH-1:0] w_s2_dst;
  logic              w_raw_hazard;
  logic              w_issue;
  logic              w_ld_en;
  logic [DWIDTH-1:0] w_rf_a;
  logic [DWIDTH-1:0] w_rf_b;
  logic [DWIDTH-1:0] w_op_a;
  logic [DWIDTH-1:0] w_op_b;

  always_comb begin
    w_s1_valid   = r_pipe_valid[0];
    w_s1_dst     = r_pipe_dst[0];
    w_s2_valid   = r_pipe_valid[S2];
    w_s2_dst     = r_pipe_dst[S2];
    // An S1 producer has no result anywhere yet, so its consumers must wait.
    w_raw_hazard = w_s1_valid && ((ins_src_a == w_s1_dst) || (ins_src_b == w_s1_dst));
    ins_ready    = !ld_valid && !w_raw_hazard;
    w_issue      = ins_valid && ins_ready;
    // Loads borrow the write port only when no writeback is due this edge.
    ld_ready     = !w_s2_valid;
    w_ld_en      = ld_valid && ld_ready;
    // S2's result is on p but not yet in the array: take it from p.
    w_op_a       = (w_s2_valid && (ins_src_a == w_s2_dst)) ? p : w_rf_a;
    w_op_b       = (w_s2_valid && (ins_src_b == w_s2_dst)) ? p : w_rf_b;
    busy         = |r_pipe_valid;
    a            = r_a;
    b            = r_b;
    subtract     = r_subtract;
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_pipe_valid <= '0;
      r_pipe_dst   <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_subtract   <= 1'b0;
    end else begin
      r_pipe_valid <= {r_pipe_valid[PIPE_DEPTH-2:0], w_issue};
      r_pipe_dst   <= {r_pipe_dst[PIPE_DEPTH-2:0], ins_dst};
      if (w_issue) begin
        r_a        <= w_op_a;
        r_b        <= w_op_b;
        r_subtract <= (op_e'(ins_sub) == OP_SUB);
      end
    end
  end

  pe_regfile #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (Resetn),
    .i_ra_addr(ins_src_a),
    .o_ra_data(w_rf_a),
    .i_rb_addr(ins_src_b),
    .o_rb_data(w_rf_b),
    .i_rd_addr(rd_addr),
    .o_rd_data(rd_data),
    .i_wb_en  (w_s2_valid),
    .i_wb_addr(w_s2_dst),
    .i_wb_data(p),
    .i_ld_en  (w_ld_en),
    .i_ld_addr(ld_addr),
    .i_ld_data(ld_data)
  );
endmodule

// File: tb/tb_pe_operand_issue.sv
// Self-checking bench for pe_operand_issue with a behavioural adder on p.
// Reference: an architectural register array updated in program order at
// each accepted instruction/load; operands, stalls and final contents are
// compared against it.
module tb_pe_operand_issue;
  import pe_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 4;
  localparam int unsigned NREG = 16;

  logic          clk = 1'b0;
  logic          Resetn;
  logic          ins_valid;
  logic          ins_ready;
  logic          ins_sub;
  logic [AW-1:0] ins_src_a;
  logic [AW-1:0] ins_src_b;
  logic [AW-1:0] ins_dst;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          subtract;
  logic [DW-1:0] p;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = -10;
  logic [AW-1:0] last_dst = '0;
  logic [DW-1:0] ref_rf [NREG];

  typedef struct {
    logic [AW-1:0] sa;
    logic [AW-1:0] sb;
    logic [AW-1:0] dst;
    logic          sub;
    logic [DW-1:0] va;
    logic [DW-1:0] vb;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder: registered, one-cycle latency, synchronous reset, wraps mod 2^32.
  always_ff @(posedge clk) begin
    if (!Resetn) p <= '0;
    else         p <= subtract ? (a - b) : (a + b);
  end

  pe_operand_issue #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .Resetn(Resetn),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_sub(ins_sub),
    .ins_src_a(ins_src_a), .ins_src_b(ins_src_b), .ins_dst(ins_dst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .a(a), .b(b), .subtract(subtract), .p(p), .busy(busy)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int waits;
    waits = 0;
    ld_valid = 1'b1; ld_addr = addr; ld_data = data;
    #1;
    while (!ld_ready && waits < 4) begin step(); waits++; end
    chk1("load_wait_le2", (waits <= 2), 1'b1);
    if (ld_ready) begin
      step();
      ref_rf[addr] = data;
    end
    ld_valid = 1'b0;
  endtask

  task automatic do_issue(input logic sub, input logic [AW-1:0] sa,
                          input logic [AW-1:0] sb, input logic [AW-1:0] dst);
    int stalls;
    int exp_stalls;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    // A consumer offered right after its producer was accepted waits one cycle.
    exp_stalls = (cyc == last_acc_cyc && (sa == last_dst || sb == last_dst)) ? 1 : 0;
    ins_valid = 1'b1; ins_sub = sub; ins_src_a = sa; ins_src_b = sb; ins_dst = dst;
    #1;
    stalls = 0;
    while (!ins_ready && stalls < 8) begin step(); stalls++; end
    chk("issue_stall_cycles", stalls, exp_stalls);
    if (!ins_ready) begin
      ins_valid = 1'b0;
      return;
    end
    ea = ref_rf[sa];
    eb = ref_rf[sb];
    step();
    ins_valid = 1'b0;
    last_acc_cyc = cyc;
    last_dst = dst;
    chk("issue_a", a, ea);
    chk("issue_b", b, eb);
    chk1("issue_subtract", subtract, sub);
    ref_rf[dst] = sub ? (ea - eb) : (ea + eb);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 8) begin step(); n++; end
    chk1("drain_busy", busy, 1'b0);
  endtask

  task automatic read_chk(input string nm, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    rd_addr = addr;
    step();
    chk(nm, rd_data, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'd1,  4'd2,  4'd3,  1'b0, 32'd5,          32'd3,          32'd8};
    vecs[1] = '{4'd1,  4'd2,  4'd4,  1'b1, 32'd0,          32'd1,          32'hFFFF_FFFF};
    vecs[2] = '{4'd9,  4'd10, 4'd11, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[3] = '{4'd12, 4'd12, 4'd13, 1'b0, 32'd100,        32'd100,        32'd200};
    vecs[4] = '{4'd14, 4'd15, 4'd0,  1'b1, 32'd7,          32'd10,         32'hFFFF_FFFD};
    vecs[5] = '{4'd6,  4'd7,  4'd6,  1'b1, 32'h1234_5678,  32'h1111_1111,  32'h0123_4567};

    for (int i = 0; i < NREG; i++) ref_rf[i] = '0;
    Resetn = 1'b0; ins_valid = 1'b0; ins_sub = 1'b0;
    ins_src_a = '0; ins_src_b = '0; ins_dst = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", a, '0);
    chk("rst_b", b, '0);
    chk1("rst_subtract", subtract, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ins_ready", ins_ready, 1'b1);
    chk1("rst_ld_ready", ld_ready, 1'b1);
    Resetn = 1'b1;
    step();

    // Table-driven single operations
    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].sa, vecs[i].va);
      if (vecs[i].sb != vecs[i].sa) do_load(vecs[i].sb, vecs[i].vb);
      do_issue(vecs[i].sub, vecs[i].sa, vecs[i].sb, vecs[i].dst);
      drain();
      read_chk("vec_result", vecs[i].dst, vecs[i].exp);
    end

    // Back-to-back dependency: one stall, then forward from p
    do_load(4'd1, 32'd5);
    do_load(4'd2, 32'd3);
    do_issue(1'b0, 4'd1, 4'd2, 4'd5);
    do_issue(1'b1, 4'd5, 4'd2, 4'd6);
    chk("hazard_fwd_a", a, 32'd8);
    drain();
    read_chk("hazard_r5", 4'd5, 32'd8);
    read_chk("hazard_r6", 4'd6, 32'd5);

    // Load arbitration against a writeback in S2
    do_issue(1'b0, 4'd1, 4'd2, 4'd11);
    step();
    ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 32'd9;
    ins_valid = 1'b1; ins_sub = 1'b0; ins_src_a = 4'd3; ins_src_b = 4'd4; ins_dst = 4'd12;
    #1;
    chk1("arb_ld_ready_s2", ld_ready, 1'b0);
    chk1("arb_ins_ready_s2", ins_ready, 1'b0);
    step();
    chk1("arb_ld_ready_free", ld_ready, 1'b1);
    chk1("arb_ins_ready_ld", ins_ready, 1'b0);
    step();
    ld_valid = 1'b0; ins_valid = 1'b0;
    ref_rf[7] = 32'd9;
    #1;
    chk1("arb_ins_ready_after", ins_ready, 1'b1);
    drain();
    read_chk("arb_r7", 4'd7, 32'd9);
    read_chk("arb_r11", 4'd11, 32'd8);

    // Independent stream: no stalls, busy falls two cycles after the last accept
    do_load(4'd1, 32'd10);
    do_load(4'd2, 32'd20);
    do_issue(1'b0, 4'd1, 4'd2, 4'd8);
    do_issue(1'b0, 4'd2, 4'd2, 4'd9);
    do_issue(1'b1, 4'd2, 4'd1, 4'd10);
    do_issue(1'b0, 4'd1, 4'd1, 4'd11);
    chk1("stream_busy_s1", busy, 1'b1);
    step();
    chk1("stream_busy_s2", busy, 1'b1);
    step();
    chk1("stream_busy_done", busy, 1'b0);
    read_chk("stream_r8", 4'd8, 32'd30);
    read_chk("stream_r9", 4'd9, 32'd40);
    read_chk("stream_r10", 4'd10, 32'd10);
    read_chk("stream_r11", 4'd11, 32'd20);

    // Reset with an op in flight
    do_issue(1'b0, 4'd1, 4'd2, 4'd8);
    Resetn = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) ref_rf[i] = '0;
    last_acc_cyc = -10;
    chk("midrst_a", a, '0);
    chk("midrst_b", b, '0);
    chk1("midrst_subtract", subtract, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk("midrst_rd_data", rd_data, '0);
    chk1("midrst_ins_ready", ins_ready, 1'b1);
    chk1("midrst_ld_ready", ld_ready, 1'b1);
    step();
    step();
    Resetn = 1'b1;
    step();
    chk1("postrst_busy", busy, 1'b0);
    read_chk("postrst_r8", 4'd8, 32'd0);
    read_chk("postrst_r1", 4'd1, 32'd0);

    // Randomized program against the architectural model
    for (int i = 0; i < NREG; i++) do_load(AW'(i), $urandom);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        drain();
        do_load(AW'($urandom_range(0, NREG - 1)), $urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        step();
      end
      do_issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)),
               AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)));
    end
    drain();
    for (int i = 0; i < NREG; i++) read_chk("rand_final_rf", AW'(i), ref_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_operand_issue.md
# pe_operand_issue

Operand issue and writeback stage placed directly upstream of the PE adder/subtractor (registered output, one-cycle latency, synchronous reset). Accepts add/sub instructions over a valid/ready handshake and reads both sources from a local register file. Drives `a`, `b` and `subtract` into the adder and writes the adder's `p` back to the destination register two cycles after issue. Handles read-after-write hazards by forwarding and stalling, and provides host load and readout ports.

## Interface
- `DWIDTH`, 32, operand/result width; matches the adder.
- `AWIDTH`, 4, register-file address width (2^AWIDTH entries).
- `clk` in 1: single clock, rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `ins_valid` in 1: instruction offered.
- `ins_ready` out 1: instruction accepted on a cycle where valid && ready.
- `ins_sub` in 1: 1 = `src_a − src_b`, 0 = `src_a + src_b`.
- `ins_src_a`, `ins_src_b`, `ins_dst` in AWIDTH each: register addresses.
- `ld_valid` in 1, `ld_ready` out 1, `ld_addr` in AWIDTH, `ld_data` in DWIDTH: host register write.
- `rd_addr` in AWIDTH, `rd_data` out DWIDTH: host readout, registered.
- `a`, `b` out DWIDTH; `subtract` out 1: registered adder operands.
- `p` in DWIDTH: adder result.
- `busy` out 1: any operation in flight.

## Operation
- **Pipeline state**
  - S1: `s1_valid`, `s1_dst` track the op whose operands are on `a`/`b`.
  - S2: `s2_valid`, `s2_dst` track the op whose result is on `p`.
  - Each edge: S2 ← S1; S1 ← the accepted instruction, or invalid if none.
- **Issue.** On accept, register `a`, `b` and `subtract`. Operand selection for each source:
  - If `s2_valid` and src == `s2_dst`: use `p` (forward).
  - Otherwise: use the register-file read.
- **Stall.** `ins_ready` = 0 when either:
  - `ld_valid` = 1 (loads have priority), or
  - `s1_valid` and (`ins_src_a` == `s1_dst` or `ins_src_b` == `s1_dst`), because the result does not exist yet.
  - Otherwise `ins_ready` = 1.
- **Writeback.** When `s2_valid`, write `p` → `regfile[s2_dst]` at the edge. Writeback never stalls.
- **Load.** `ld_ready` = !`s2_valid`. On accept, write `ld_data` → `regfile[ld_addr]`. Loads wait at most 2 cycles, since issue is blocked while `ld_valid` is high.
- **Readout.** `rd_data` ← `regfile[rd_addr]` each cycle. Reads the raw array: no forwarding and no ordering against in-flight ops.
- **Arithmetic.** Done by the adder, wraps modulo 2^DWIDTH. This block performs no arithmetic.
- **Idle outputs.** When no instruction is accepted, `a`, `b` and `subtract` hold their previous values. The adder still computes, but S2 is invalid, so no writeback occurs.
- `busy` = `s1_valid` | `s2_valid`.

## Timing
- **Reset values:** `a` = 0, `b` = 0, `subtract` = 0, `rd_data` = 0, `s1_valid` = `s2_valid` = 0, all register-file entries = 0, `busy` = 0.
  - `ins_ready` = 1 and `ld_ready` = 1 during and after reset, unless `ld_valid` is high.
- **Latency:** instruction accepted at edge E0 → operands valid after E0 → `p` valid after E1 → register written at E2.
  - A dependent instruction may issue at E1 (forwarded from `p` at E1→E2, i.e. accepted at E1 using `p`), or later.
- **Dependent issue window:**
  - Back-to-back dependent instructions stall exactly 1 cycle.
  - An instruction accepted in the cycle after that stall forwards from `p`.
- **Same-cycle writeback and read of the same address:** the read returns the old array value. The forward path covers this case.
- **`src_a` == `src_b`:** both operands take the same selection.
- **`ins_dst` == `s2_dst`:** no special handling; the later writeback wins.
- **Reset mid-operation:** S1 and S2 are cleared immediately. In-flight results are never written, even though `p` still shows a stale value.

## Structure
- **`pe_pkg`:**
  - Default `DWIDTH`/`AWIDTH`.
  - `ADD_LAT` = 1, the adder latency used to size S1/S2.
  - Sub encoding constant (`OP_ADD` = 0, `OP_SUB` = 1).
- **Sub-module `pe_regfile`:**
  - 2 combinational read ports.
  - 1 registered read port (host readout).
  - 1 write port with a mux between writeback and load. Mutually exclusive by construction; assert this in simulation.
  - Async reset to 0.
- **Top:** hazard/forward logic, S1/S2 registers, handshake.

## Test plan
- **Load and add.** Load r1 = 5, r2 = 3; issue add r3 = r1 + r2, then wait 3 cycles.
  - Expect `a` = 5, `b` = 3 and `subtract` = 0 the cycle after accept.
  - Readout of r3 = 8.
- **Subtract wrap.** r1 = 0, r2 = 1; sub r4 = r1 − r2.
  - Expect r4 = 0xFFFFFFFF.
- **Hazard.** Issue add r5 = r1 + r2 (5, 3), immediately followed by sub r6 = r5 − r2.
  - Expect `ins_ready` = 0 for 1 cycle.
  - Second instruction accepted with `a` forwarded as 8; r6 = 5.
- **Load arbitration.** Hold `ld_valid` = 1 (r7 = 9) while an add is in S2.
  - Expect `ld_ready` = 0 that cycle, and `ins_ready` = 0 throughout.
  - Load completes within 2 cycles; r7 = 9.
- **Reset mid-flight.** Issue add r8 = r1 + r2, then assert `Resetn` = 0 one cycle later.
  - Expect all outputs at reset values, `busy` = 0, r8 = 0 after release.
- **Independent stream.** Issue 4 independent adds on consecutive cycles.
  - Expect `ins_ready` held at 1, four writebacks on consecutive edges, correct sums.
